// File: rtl/apb4_wdg_win.sv
// ---------------------------------------------------------------------------
// apb4_wdg_win : windowed APB4 watchdog with early warning, sticky config
//                lock and a stretched fixed-length reset request.
//
// Ports
//   clk_i, rst_n_i         APB clock / asynchronous active-low reset
//   paddr, psel, penable,  APB4 slave interface, word index paddr[5:2],
//   pwrite, pwdata,        zero wait states (pready tied high),
//   prdata, pready,        pslverr flags a rejected protected write
//   pslverr
//   tick_i                 external tick, asynchronous (RTC domain)
//   irq_o                  early-warning interrupt, level
//   rst_o                  SoC reset request, RST_CYC-cycle active-high pulse
//
// Register map (word index)
//   0 CTRL  [0] WARNIE [1] ETR [2] EN [3] WINEN [4] LOCK (set-only)
//   1 PSCR  prescaler reload          5 WARN  warning count
//   2 CNT   counter (read-only)       6 STAT  [0] WARNIF [1] TOIF [2] EWIF, W1C
//   3 CMP   timeout compare           7 KEY   write KEY_VAL; reads key_ok
//   4 WIN   window open count         8 FEED  write bit0=1 to feed
// CTRL/PSCR/CMP/WIN/WARN/FEED need a preceding KEY write; once LOCK is set
// only FEED stays writable.
// ---------------------------------------------------------------------------
module apb4_wdg_win #(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned PSCR_WIDTH = 20,
   parameter int unsigned RST_CYC    = 16,
   parameter logic [31:0] KEY_VAL    = 32'h5F37_59DF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        tick_i,
   output logic        irq_o,
   output logic        rst_o
);

   localparam logic [3:0] REG_CTRL = 4'd0;
   localparam logic [3:0] REG_PSCR = 4'd1;
   localparam logic [3:0] REG_CNT  = 4'd2;
   localparam logic [3:0] REG_CMP  = 4'd3;
   localparam logic [3:0] REG_WIN  = 4'd4;
   localparam logic [3:0] REG_WARN = 4'd5;
   localparam logic [3:0] REG_STAT = 4'd6;
   localparam logic [3:0] REG_KEY  = 4'd7;
   localparam logic [3:0] REG_FEED = 4'd8;

   localparam int unsigned        RCNT_W    = $clog2(RST_CYC + 1);
   localparam logic [RCNT_W-1:0]  RCNT_LOAD = RCNT_W'(RST_CYC);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                  warnie_q, etr_q, en_q, winen_q, lock_q;
   logic [PSCR_WIDTH-1:0] pscr_q, pcnt_q, pcnt_d;
   logic [CNT_WIDTH-1:0]  cmp_q, win_q, warn_q;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [2:0]            stat_q, stat_d;
   logic                  key_ok_q;
   logic [2:0]            sync_q;
   logic                  irq_q;
   logic [RCNT_W-1:0]     rcnt_q, rcnt_d;

   // ------------------------------------------------------------------
   // APB decode
   // ------------------------------------------------------------------
   logic [3:0] idx;
   logic       wr, rd, is_prot, wr_ok;
   logic       wr_ctrl, wr_pscr, wr_cmp, wr_win, wr_warn, wr_stat, feed;

   assign idx     = paddr[5:2];
   assign wr      = psel & penable & pwrite;
   assign rd      = psel & penable & ~pwrite;
   assign pready  = 1'b1;

   assign is_prot = (idx == REG_CTRL) | (idx == REG_PSCR) | (idx == REG_CMP) |
                    (idx == REG_WIN)  | (idx == REG_WARN) | (idx == REG_FEED);
   // LOCK freezes the configuration but must never stop the feed path.
   assign wr_ok   = key_ok_q & (~lock_q | (idx == REG_FEED));
   assign pslverr = wr & is_prot & ~wr_ok;

   assign wr_ctrl = wr & wr_ok & (idx == REG_CTRL);
   assign wr_pscr = wr & wr_ok & (idx == REG_PSCR);
   assign wr_cmp  = wr & wr_ok & (idx == REG_CMP);
   assign wr_win  = wr & wr_ok & (idx == REG_WIN);
   assign wr_warn = wr & wr_ok & (idx == REG_WARN);
   assign wr_stat = wr & (idx == REG_STAT);
   assign feed    = en_q & wr & wr_ok & (idx == REG_FEED) & pwdata[0];

   // Upper/lower address bits carry no information for this block.
   logic unused_paddr;
   assign unused_paddr = ^{paddr[31:6], paddr[1:0]};

   // ------------------------------------------------------------------
   // Tick generation
   // ------------------------------------------------------------------
   logic tick_int, tick_ext, tick;

   assign tick_int = (pcnt_q == pscr_q);
   // sync_q[1] is the second synchroniser stage; sync_q[2] only remembers
   // its previous value so a held-high tick_i yields a single tick.
   assign tick_ext = sync_q[1] & ~sync_q[2];
   assign tick     = en_q & (etr_q ? tick_ext : tick_int);

   // ------------------------------------------------------------------
   // Counter / event next-state
   // ------------------------------------------------------------------
   logic to_evt, ewif_evt, warn_evt;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      to_evt   = 1'b0;
      ewif_evt = 1'b0;
      warn_evt = 1'b0;

      if (!en_q || etr_q)
         pcnt_d = '0;
      else if (tick_int)
         pcnt_d = '0;
      else
         pcnt_d = pcnt_q + PSCR_WIDTH'(1);

      if (!en_q) begin
         cnt_d = '0;
      end else if (feed) begin
         // Feed outranks a same-cycle tick, including a timeout tick.
         cnt_d    = '0;
         pcnt_d   = '0;
         ewif_evt = winen_q & (cnt_q < win_q);
      end else if (tick) begin
         if (cnt_q >= cmp_q) begin
            to_evt = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            warn_evt = (cnt_d == warn_q) && (warn_q != '0);
         end
      end

      if (wr_pscr)
         pcnt_d = '0;
   end

   // Set beats clear when both land in the same cycle.
   always_comb begin
      stat_d = stat_q;
      if (wr_stat)
         stat_d = stat_q & ~pwdata[2:0];
      stat_d = stat_d | {ewif_evt, to_evt, warn_evt};
   end

   // A retrigger during the pulse simply reloads the length.
   always_comb begin
      if (to_evt || ewif_evt)
         rcnt_d = RCNT_LOAD;
      else if (rcnt_q != '0)
         rcnt_d = rcnt_q - RCNT_W'(1);
      else
         rcnt_d = '0;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         warnie_q <= 1'b0;
         etr_q    <= 1'b0;
         en_q     <= 1'b0;
         winen_q  <= 1'b0;
         lock_q   <= 1'b0;
         pscr_q   <= '0;
         pcnt_q   <= '0;
         cmp_q    <= '0;
         win_q    <= '0;
         warn_q   <= '0;
         cnt_q    <= '0;
         stat_q   <= '0;
         key_ok_q <= 1'b0;
         sync_q   <= '0;
         irq_q    <= 1'b0;
         rcnt_q   <= '0;
      end else begin
         if (wr_ctrl) begin
            warnie_q <= pwdata[0];
            etr_q    <= pwdata[1];
            en_q     <= pwdata[2];
            winen_q  <= pwdata[3];
            lock_q   <= lock_q | pwdata[4];
         end
         if (wr_pscr) pscr_q <= PSCR_WIDTH'(pwdata);
         if (wr_cmp)  cmp_q  <= CNT_WIDTH'(pwdata);
         if (wr_win)  win_q  <= CNT_WIDTH'(pwdata);
         if (wr_warn) warn_q <= CNT_WIDTH'(pwdata);

         // Any write consumes the key; only a correct KEY write re-arms it.
         if (wr)
            key_ok_q <= (idx == REG_KEY) && (pwdata == KEY_VAL);

         pcnt_q <= pcnt_d;
         cnt_q  <= cnt_d;
         stat_q <= stat_d;
         sync_q <= {sync_q[1:0], tick_i};
         irq_q  <= stat_q[0] & warnie_q;
         rcnt_q <= rcnt_d;
      end
   end

   assign irq_o = irq_q;
   assign rst_o = (rcnt_q != '0);

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   always_comb begin
      prdata = '0;
      if (rd) begin
         case (idx)
            REG_CTRL: prdata = {27'd0, lock_q, winen_q, en_q, etr_q, warnie_q};
            REG_PSCR: prdata = 32'(pscr_q);
            REG_CNT:  prdata = 32'(cnt_q);
            REG_CMP:  prdata = 32'(cmp_q);
            REG_WIN:  prdata = 32'(win_q);
            REG_WARN: prdata = 32'(warn_q);
            REG_STAT: prdata = {29'd0, stat_q};
            REG_KEY:  prdata = {31'd0, key_ok_q};
            default:  prdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb4_wdg_win.sv
// ---------------------------------------------------------------------------
// tb_apb4_wdg_win : directed self-checking bench for apb4_wdg_win.
// Cycle numbers in comments count from the cycle right after the write that
// set EN (cycle 0), with the prescaler starting at 0 in that cycle.
// ---------------------------------------------------------------------------
module tb_apb4_wdg_win;

   localparam logic [31:0] KEY    = 32'h5F37_59DF;
   localparam logic [31:0] A_CTRL = 32'h00;
   localparam logic [31:0] A_PSCR = 32'h04;
   localparam logic [31:0] A_CNT  = 32'h08;
   localparam logic [31:0] A_CMP  = 32'h0C;
   localparam logic [31:0] A_WIN  = 32'h10;
   localparam logic [31:0] A_WARN = 32'h14;
   localparam logic [31:0] A_STAT = 32'h18;
   localparam logic [31:0] A_KEY  = 32'h1C;
   localparam logic [31:0] A_FEED = 32'h20;
   localparam logic [31:0] A_UNM  = 32'h30;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        tick_i;
   logic        irq_o, rst_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   apb4_wdg_win dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr),
      .tick_i  (tick_i),
      .irq_o   (irq_o),
      .rst_o   (rst_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Setup phase in one cycle, access phase in the next; commit on the
   // posedge ending the access cycle; returns 1 time unit after that edge.
   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
      @(negedge clk);
      paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1 err = pslverr;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err);
      logic e;
      apb_wr(a, d, e);
      check(tag, {31'd0, e}, {31'd0, exp_err});
   endtask

   task automatic kwr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err);
      logic e;
      apb_wr(A_KEY, KEY, e);
      apb_wr(a, d, e);
      check(tag, {31'd0, e}, {31'd0, exp_err});
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      pwdata = '0; tick_i = 1'b0;

      // ---------------- reset state ----------------
      #12;
      check("rst_rst_o",   {31'd0, rst_o},   32'd0);
      check("rst_irq_o",   {31'd0, irq_o},   32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_prdata",  prdata,           32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("rst_ctrl", A_CTRL, 32'd0);
      rd_chk("rst_cnt",  A_CNT,  32'd0);
      rd_chk("rst_stat", A_STAT, 32'd0);
      rd_chk("rst_key",  A_KEY,  32'd0);
      check("pready", {31'd0, pready}, 32'd1);

      // ---------------- key gating ----------------
      wr_chk ("nokey_cmp_err", A_CMP, 32'd10, 1'b1);
      rd_chk ("nokey_cmp_rd",  A_CMP, 32'd0);
      wr_chk ("key_wr_err",    A_KEY, KEY, 1'b0);
      rd_chk ("key_rd_ok",     A_KEY, 32'd1);
      wr_chk ("key_cmp_err",   A_CMP, 32'd10, 1'b0);
      rd_chk ("key_cmp_rd",    A_CMP, 32'd10);
      rd_chk ("key_consumed",  A_KEY, 32'd0);
      wr_chk ("rekey_cmp_err", A_CMP, 32'd20, 1'b1);
      rd_chk ("rekey_cmp_rd",  A_CMP, 32'd10);
      wr_chk ("badkey_err",    A_KEY, 32'h1234_5678, 1'b0);
      rd_chk ("badkey_rd",     A_KEY, 32'd0);
      wr_chk ("badkey_cmp",    A_CMP, 32'd30, 1'b1);
      wr_chk ("key_again",     A_KEY, KEY, 1'b0);
      wr_chk ("unm_wr",        A_UNM, 32'hFFFF_FFFF, 1'b0);
      rd_chk ("unm_rd",        A_UNM, 32'd0);
      rd_chk ("unm_key_used",  A_KEY, 32'd0);

      // ---------------- timeout / warning / reset pulse ----------------
      do_reset();
      kwr_chk("to_pscr", A_PSCR, 32'd3, 1'b0);
      kwr_chk("to_cmp",  A_CMP,  32'd5, 1'b0);
      kwr_chk("to_warn", A_WARN, 32'd3, 1'b0);
      kwr_chk("to_ctrl", A_CTRL, 32'h5, 1'b0);
      // ticks at cycles 3,7,11,...; cnt hits WARN=3 at cycle 11 (irq at 13),
      // cnt=5 at tick 23 -> timeout, rst_o high in cycles 24..39.
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 12) check("irq_before", {31'd0, irq_o}, 32'd0);
         if (c == 13) check("irq_rise",   {31'd0, irq_o}, 32'd1);
         if (c == 23) check("rst_before", {31'd0, rst_o}, 32'd0);
         if (c == 24) check("rst_first",  {31'd0, rst_o}, 32'd1);
         if (c == 39) check("rst_last",   {31'd0, rst_o}, 32'd1);
         if (c == 40) check("rst_after",  {31'd0, rst_o}, 32'd0);
      end
      rd_chk("to_stat",      A_STAT, 32'd3);
      wr_chk("stat_w1c_err", A_STAT, 32'd1, 1'b0);
      rd_chk("stat_w1c",     A_STAT, 32'd2);
      check("irq_cleared", {31'd0, irq_o}, 32'd0);

      // ---------------- periodic feeding ----------------
      do_reset();
      kwr_chk("fd_pscr", A_PSCR, 32'd3, 1'b0);
      kwr_chk("fd_cmp",  A_CMP,  32'd5, 1'b0);
      kwr_chk("fd_ctrl", A_CTRL, 32'h4, 1'b0);
      begin
         int bad_err = 0;
         int rst_seen = 0;
         for (int i = 0; i < 25; i++) begin
            logic e;
            apb_wr(A_KEY, KEY, e);
            apb_wr(A_FEED, 32'd1, e);
            if (e) bad_err++;
            for (int k = 0; k < 12; k++) begin
               @(posedge clk);
               #1;
               if (rst_o) rst_seen++;
            end
         end
         check("fd_errs",  bad_err,  32'd0);
         check("fd_rst_o", rst_seen, 32'd0);
      end
      rd_chk("fd_stat", A_STAT, 32'd0);

      // ---------------- feed on a timeout tick ----------------
      do_reset();
      kwr_chk("ft_pscr", A_PSCR, 32'd3, 1'b0);
      kwr_chk("ft_cmp",  A_CMP,  32'd1, 1'b0);
      kwr_chk("ft_ctrl", A_CTRL, 32'h4, 1'b0);
      // tick 3: cnt 0->1; tick 7 would time out; FEED access lands in cycle 7.
      repeat (4) @(posedge clk);
      kwr_chk("ft_feed", A_FEED, 32'd1, 1'b0);
      check("ft_no_rst", {31'd0, rst_o}, 32'd0);
      rd_chk("ft_cnt",  A_CNT,  32'd0);
      rd_chk("ft_stat", A_STAT, 32'd0);
      // unfed: tick 11 -> cnt 1, tick 15 times out, rst_o from cycle 16
      repeat (4) @(posedge clk);
      #1;
      check("ft_unfed_to", {31'd0, rst_o}, 32'd1);

      // ---------------- window ----------------
      do_reset();
      kwr_chk("wn_pscr", A_PSCR, 32'd1,   1'b0);
      kwr_chk("wn_cmp",  A_CMP,  32'd100, 1'b0);
      kwr_chk("wn_win",  A_WIN,  32'd3,   1'b0);
      rd_chk ("wn_win_rd", A_WIN, 32'd3);
      kwr_chk("wn_ctrl", A_CTRL, 32'hC,   1'b0);
      // ticks every 2nd cycle (1,3,5,..): cnt=2 in cycles 4..5; feed at 5
      repeat (2) @(posedge clk);
      kwr_chk("wn_feed_early", A_FEED, 32'd1, 1'b0);
      check("wn_rst_o", {31'd0, rst_o}, 32'd1);
      rd_chk("wn_ewif", A_STAT, 32'd4);
      wr_chk("wn_clr",  A_STAT, 32'd7, 1'b0);
      // relative to the early feed: cnt=3 in cycles 6..7; feed at 7
      kwr_chk("wn_feed_ok", A_FEED, 32'd1, 1'b0);
      rd_chk("wn_no_ewif", A_STAT, 32'd0);
      // first pulse covers relative cycles 0..15; a retrigger would extend it
      repeat (6) @(posedge clk);
      #1;
      check("wn_pulse_end", {31'd0, rst_o}, 32'd0);

      // ---------------- lock ----------------
      do_reset();
      kwr_chk("lk_cmp",  A_CMP,  32'd50,  1'b0);
      kwr_chk("lk_pscr", A_PSCR, 32'd0,   1'b0);
      kwr_chk("lk_ctrl", A_CTRL, 32'h14,  1'b0);
      kwr_chk("lk_ctrl_rej", A_CTRL, 32'd0, 1'b1);
      rd_chk ("lk_ctrl_rd",  A_CTRL, 32'h14);
      wr_chk ("lk_feed_nokey", A_FEED, 32'd1, 1'b1);
      kwr_chk("lk_feed", A_FEED, 32'd1, 1'b0);
      // tick every cycle: cnt=0 in cycle 0, read samples cycle 1
      rd_chk ("lk_cnt_fed", A_CNT, 32'd1);
      kwr_chk("lk_pscr_rej", A_PSCR, 32'd5, 1'b1);
      begin
         int w = 0;
         while (!rst_o && w < 200) begin
            @(posedge clk);
            #1;
            w++;
         end
         check("lk_to_seen", {31'd0, rst_o}, 32'd1);
      end
      rd_chk("lk_stat", A_STAT, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("lk_async_rst_o", {31'd0, rst_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("lk_ctrl_cleared", A_CTRL, 32'd0);
      rd_chk("lk_stat_cleared", A_STAT, 32'd0);
      check("lk_rst_o_cleared", {31'd0, rst_o}, 32'd0);

      // ---------------- external tick ----------------
      do_reset();
      kwr_chk("et_cmp",  A_CMP,  32'd100, 1'b0);
      kwr_chk("et_ctrl", A_CTRL, 32'h6,   1'b0);
      for (int i = 0; i < 8; i++) begin
         tick_i = 1'b1;
         #37;
         tick_i = 1'b0;
         #43;
      end
      #50;
      rd_chk("et_cnt8", A_CNT, 32'd8);
      tick_i = 1'b1;
      #200;
      rd_chk("et_cnt9", A_CNT, 32'd9);
      #200;
      rd_chk("et_hold", A_CNT, 32'd9);
      tick_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb4_wdg_win.md
Name: apb4_wdg_win

Overview:
- Parametrised next-generation APB4 watchdog for the peripheral subsystem.
- Adds to the existing watchdog:
  - configurable counter and prescaler widths;
  - windowed (early-feed) fault detection;
  - a programmable early-warning interrupt;
  - a sticky configuration lock;
  - a stretched, fixed-length reset pulse.
- Sits on the APB4 peripheral bus. Drives the SoC reset controller and the interrupt controller.

Parameters:
- CNT_WIDTH, 32: width of the counter and of the CMP/WIN/WARN registers.
- PSCR_WIDTH, 20: width of the prescaler register and internal prescaler counter.
- RST_CYC, 16: rst_o pulse length in clk_i cycles (≥1).
- KEY_VAL, 32'h5F37_59DF: unlock key.

Ports:
- clk_i  in  1  APB clock (pclk).
- rst_n_i  in  1  asynchronous active-low reset (presetn).
- paddr  in  32  APB address; word index paddr[5:2].
- psel, penable, pwrite  in  1 each  APB control.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  tied 1.
- pslverr  out  1  rejected-write error.
- tick_i  in  1  asynchronous external tick (RTC domain).
- irq_o  out  1  warning interrupt, level.
- rst_o  out  1  SoC reset request, active-high pulse.

Behaviour:
- Clock/reset: single clock clk_i; rst_n_i asynchronous, active-low.
- Reset values: all registers, counters and sync flops 0; prdata 0; pslverr 0; irq_o 0; rst_o 0.
- Access rules:
  - wr = psel&penable&pwrite; rd = psel&penable&~pwrite.
  - Zero wait states.
  - prdata is combinational during rd, else 0.
- Register map (word index):
  - 0 CTRL
  - 1 PSCR
  - 2 CNT (RO)
  - 3 CMP
  - 4 WIN
  - 5 WARN
  - 6 STAT
  - 7 KEY
  - 8 FEED
  - Unmapped indices read 0 and ignore writes.
- Key:
  - A write of KEY_VAL to KEY sets key_ok.
  - Any other wr, including a wrong KEY value, clears key_ok the following cycle.
  - The key therefore authorises exactly one subsequent write.
  - KEY reads back 1 when key_ok, else 0.
- Protected registers (CTRL, PSCR, CMP, WIN, WARN, FEED):
  - Write takes effect only if key_ok and (LOCK=0 or target is FEED).
  - A rejected protected write drives pslverr=1 in its access cycle.
- CTRL bits:
  - [0] WARNIE
  - [1] ETR (external tick)
  - [2] EN
  - [3] WINEN
  - [4] LOCK: set-only; cleared only by rst_n_i.
- Tick source:
  - ETR=0: prescaler pcnt counts 0..PSCR; tick when pcnt==PSCR, then pcnt←0. PSCR=0 gives a tick every cycle. A PSCR write clears pcnt.
  - ETR=1: tick_i passes a 2-flop synchroniser; tick = synchronised rising edge (one cycle).
- Counter, when EN=1 (priority order, top wins):
  - Valid FEED write (key_ok, pwdata[0]=1): cnt←0, pcnt←0.
    - If WINEN and cnt<WIN at the feed cycle, this is an early-window fault (EWIF).
    - Feed wins over a same-cycle tick or timeout.
  - Tick with cnt≥CMP: timeout (TOIF), cnt←0.
    - CMP=0 times out on every tick.
    - Lowering CMP below cnt times out on the next tick.
  - Tick otherwise: cnt←cnt+1. If the new value ==WARN and WARN≠0, set WARNIF.
- Counter, when EN=0: cnt and pcnt held at 0; no ticks, faults or warnings.
- STAT:
  - Bits: [0] WARNIF, [1] TOIF, [2] EWIF.
  - Write-1-to-clear; no key required.
  - A same-cycle set beats a clear.
- irq_o = WARNIF & WARNIE, registered from the flag (1 cycle after the setting tick).
- rst_o:
  - Timeout or EWIF loads rcnt←RST_CYC; rst_o = (rcnt≠0); rcnt decrements each cycle.
  - A retrigger during the pulse reloads rcnt.
  - rst_o does not reset this block; STAT survives for post-mortem.
  - Pulse is high exactly RST_CYC cycles starting the cycle after the event.
- Mid-operation rst_n_i: everything clears immediately (asynchronous), including LOCK and an in-flight rst_o pulse.
- Arithmetic: cnt is unsigned CNT_WIDTH; compares are unsigned; no wrap is possible since cnt≥CMP forces 0.

Test Plan:
- Key gating:
  - Write CMP=10 without key → pslverr=1, CMP reads 0.
  - KEY=5F3759DF then CMP=10 → CMP=10.
  - A second CMP write without re-key is rejected.
- Timeout:
  - PSCR=3, CMP=5, WARN=3, CTRL=0x5 (EN|WARNIE), each keyed.
  - Expect TOIF at the 6th tick (24 cycles).
  - irq_o rises at tick 3.
  - rst_o high exactly 16 cycles, then 0.
- Feeding:
  - Keyed FEED every 4 ticks with CMP=5 → TOIF never sets over 100 ticks.
  - Feed in the same cycle as a timeout tick → no TOIF, cnt=0.
- Window:
  - WIN=3, WINEN=1.
  - Feed at cnt=2 → EWIF=1, rst_o pulse.
  - Feed at cnt=3 → no fault.
- Lock:
  - Set LOCK.
  - Keyed CTRL=0 → pslverr=1, EN stays 1.
  - Keyed FEED still accepted.
  - Assert rst_n_i → LOCK, STAT, rst_o all 0.
- External tick:
  - ETR=1; 8 tick_i edges, asynchronous to clk_i → CNT=8.
  - Holding tick_i high adds no ticks.
